// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit active-low 7-segment controller.
// Captures a binary value on load and renders it as hex (single cycle) or
// unsigned decimal (sequential double-dabble), with leading-zero blanking,
// overflow dashes and a free-running blink mask on the registered output.
module seg_display_ctrl #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_W-1:0]     value,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic                  busy,
   output logic                  valid,
   output logic [7*DIGITS-1:0]   hex_out
);

   // Number of decimal digits needed to hold 2^w - 1.
   function automatic int unsigned f_dec_digits(input int unsigned w);
      longint unsigned m;
      int unsigned     d;
      m = (longint'(1) << w) - 1;
      d = 1;
      while (m >= 10) begin
         m = m / 10;
         d = d + 1;
      end
      return d;
   endfunction

   localparam int unsigned BCD_D = f_dec_digits(DATA_W);
   localparam int unsigned NW    = 4 * DIGITS;
   localparam int unsigned HW    = (DATA_W > NW) ? DATA_W : NW;
   localparam int unsigned BW    = (4 * BCD_D > NW) ? 4 * BCD_D : NW;
   localparam int unsigned DDW   = 4 * BCD_D + DATA_W;
   localparam int unsigned IW    = $clog2(DATA_W);
   localparam int unsigned CW    = $clog2(BLINK_DIV + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;

   // Active-low glyph for one nibble, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] f_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h18;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h27;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Full display image from a digit vector; overflow forces dashes and
   // suppresses blanking, digit 0 is never blanked.
   function automatic logic [7*DIGITS-1:0] f_render(
      input logic [NW-1:0] nibs,
      input logic          ovf,
      input logic          blz
   );
      logic [7*DIGITS-1:0] img;
      logic                lead;
      logic [3:0]          nib;
      int unsigned         idx;
      img  = '1;
      lead = 1'b1;
      for (int unsigned k = DIGITS; k > 0; k--) begin
         idx = k - 1;
         nib = nibs[4*idx +: 4];
         if (ovf) begin
            img[7*idx +: 7] = 7'h3F;
         end else if (blz && lead && (nib == 4'h0) && (idx != 0)) begin
            img[7*idx +: 7] = 7'h7F;
         end else begin
            img[7*idx +: 7] = f_glyph(nib);
            lead            = 1'b0;
         end
      end
      return img;
   endfunction

   state_t               r_state;
   state_t               w_state_next;
   logic [DDW-1:0]       r_dd;        // {bcd digits, binary shift register}
   logic [DDW-1:0]       w_dd_adj;
   logic [IW-1:0]        r_iter;
   logic                 r_blz;
   logic [7*DIGITS-1:0]  r_img;
   logic                 r_hex_pend;
   logic [CW-1:0]        r_blink_cnt;
   logic                 r_phase;

   logic [HW-1:0]        w_hex_pad;
   logic                 w_hex_ovf;
   logic [BW-1:0]        w_bcd_pad;
   logic                 w_dec_ovf;
   logic [7*DIGITS-1:0]  w_dec_img;
   logic [7*DIGITS-1:0]  w_show;

   assign busy      = (r_state != IDLE);

   assign w_hex_pad = HW'(value);
   assign w_hex_ovf = |(w_hex_pad >> NW);
   assign w_bcd_pad = BW'(r_dd[DDW-1:DATA_W]);
   assign w_dec_ovf = |(w_bcd_pad >> NW);
   assign w_dec_img = f_render(w_bcd_pad[NW-1:0], w_dec_ovf, r_blz);
   // The decimal image goes straight to the output stage on the EMIT edge,
   // so it is not delayed behind r_img.
   assign w_show    = (r_state == EMIT) ? w_dec_img : r_img;

   // Double-dabble adjust: add 3 to every BCD digit of 5 or more.
   always_comb begin
      w_dd_adj = r_dd;
      for (int unsigned i = 0; i < BCD_D; i++) begin
         if (r_dd[DATA_W + 4*i +: 4] >= 4'd5) begin
            w_dd_adj[DATA_W + 4*i +: 4] = r_dd[DATA_W + 4*i +: 4] + 4'd3;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state: decimal loads run DATA_W iterations then one EMIT cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (load && dec_mode) begin
               w_state_next = CONV;
            end
         end
         CONV: begin
            if (r_iter == IW'(DATA_W - 1)) begin
               w_state_next = EMIT;
            end
         end
         EMIT: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Capture, conversion datapath and stored image.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_dd       <= '0;
         r_iter     <= '0;
         r_blz      <= 1'b0;
         r_img      <= '1;
         r_hex_pend <= 1'b0;
      end else begin
         r_hex_pend <= 1'b0;
         case (r_state)
            IDLE: begin
               if (load) begin
                  if (dec_mode) begin
                     r_dd   <= {{(4*BCD_D){1'b0}}, value};
                     r_iter <= '0;
                     r_blz  <= blank_lz;
                  end else begin
                     r_img      <= f_render(w_hex_pad[NW-1:0], w_hex_ovf, blank_lz);
                     r_hex_pend <= 1'b1;
                  end
               end
            end
            CONV: begin
               r_dd   <= w_dd_adj << 1;
               r_iter <= r_iter + IW'(1);
            end
            EMIT: begin
               r_img <= w_dec_img;
            end
            default: ;
         endcase
      end
   end

   // Free-running blink divider; phase toggles on every wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + CW'(1);
      end
   end

   // Registered output stage: blink mask over the current image, valid pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hex_out <= '1;
         valid   <= 1'b0;
      end else begin
         hex_out <= (blink_en && r_phase) ? '1 : w_show;
         valid   <= (r_state == EMIT) || r_hex_pend;
      end
   end

endmodule
